dmem_unit: RTL and testbench

DMEM_UNIT -- requirements
Module: dmem_unit

---
 rtl/dmem_unit.sv | 131 +++++++++++++
 tb/tb_dmem_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_unit.sv
// Byte-addressed big-endian data memory with a fixed-latency request/response handshake.
// One request in flight at a time; loads sample and stores commit on the acceptance edge.
module dmem_unit #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  if (LATENCY < 1 || LATENCY > 16) begin : g_bad_latency
    $error("dmem_unit: LATENCY must be in 1..16");
  end
  if (DEPTH_BYTES < 4 || DEPTH_BYTES > 65536 || (DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0) begin : g_bad_depth
    $error("dmem_unit: DEPTH_BYTES must be a power of two in 4..65536");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        accept;
  logic        err;
  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [7:0]  b0, b1, b2, b3;
  logic [31:0] load_data;
  logic [31:0] data_q;
  logic        err_q;
  logic [7:0]  mem [DEPTH_BYTES];

  assign accept = req_valid && (state == IDLE) && !reset;

  // Request decode: legality check and big-endian byte gather for loads
  always_comb begin
    nbytes = 3'd1;
    case (req_size)
      2'b01:   nbytes = 3'd2;
      2'b10:   nbytes = 3'd4;
      default: nbytes = 3'd1;
    endcase
    end_addr = {1'b0, req_addr} + 33'(nbytes);
    err = (req_size == 2'b11)
       || (req_size == 2'b01 && req_addr[0])
       || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
       || (end_addr > 33'(DEPTH_BYTES));
    a0 = req_addr[AW-1:0];
    a1 = a0 + AW'(1);
    a2 = a0 + AW'(2);
    a3 = a0 + AW'(3);
    b0 = mem[a0];
    b1 = mem[a1];
    b2 = mem[a2];
    b3 = mem[a3];
    case (req_size)
      2'b00:   load_data = {{24{req_signed & b0[7]}}, b0};
      2'b01:   load_data = {{16{req_signed & b0[7]}}, b0, b1};
      default: load_data = {b0, b1, b2, b3};
    endcase
  end

  // Array has no reset so contents survive it
  always_ff @(posedge clk) begin
    if (accept && req_write && !err) begin
      case (req_size)
        2'b00: mem[a0] <= req_wdata[7:0];
        2'b01: begin
          mem[a0] <= req_wdata[15:8];
          mem[a1] <= req_wdata[7:0];
        end
        2'b10: begin
          mem[a0] <= req_wdata[31:24];
          mem[a1] <= req_wdata[23:16];
          mem[a2] <= req_wdata[15:8];
          mem[a3] <= req_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      cnt    <= 4'(LATENCY - 1);
      data_q <= (err || req_write) ? '0 : load_data;
      err_q  <= err;
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE) && !reset;
    resp_valid = (state == RESP);
    resp_rdata = resp_valid ? data_q : '0;
    resp_err   = resp_valid && err_q;
  end

endmodule

// File: tb/tb_dmem_unit.sv
// Bench for dmem_unit: two instances (LATENCY 1 and 4) checked each cycle against a
// deadline-based model of the request/response protocol and a byte-array memory model.
module tb_dmem_unit;

  localparam int D = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        v[2], w[2], sg[2];
  logic [1:0]  sz[2];
  logic [31:0] ad[2], wd[2];
  logic        rdy[2], rv[2], re[2];
  logic [31:0] rd[2];

  dmem_unit #(.DEPTH_BYTES(D), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .req_valid(v[0]), .req_ready(rdy[0]), .req_write(w[0]),
    .req_size(sz[0]), .req_signed(sg[0]), .req_addr(ad[0]), .req_wdata(wd[0]),
    .resp_valid(rv[0]), .resp_rdata(rd[0]), .resp_err(re[0])
  );

  dmem_unit #(.DEPTH_BYTES(D), .LATENCY(4)) u_lat4 (
    .clk(clk), .reset(reset), .req_valid(v[1]), .req_ready(rdy[1]), .req_write(w[1]),
    .req_size(sz[1]), .req_signed(sg[1]), .req_addr(ad[1]), .req_wdata(wd[1]),
    .resp_valid(rv[1]), .resp_rdata(rd[1]), .resp_err(re[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy[2], resp_at[2], acc_cyc[2], resp_cyc[2];
  bit pend[2], exp_e[2], exp_known[2];
  logic [31:0] exp_d[2];
  logic [7:0]  mm[2][D];
  bit          mk[2][D];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int nb_of(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit is_err(input logic [1:0] s, input logic [31:0] a);
    longint last;
    last = longint'({32'd0, a}) + longint'(nb_of(s)) - 1;
    return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00) || (last >= D);
  endfunction

  // Model: request accepted when the model believes the unit is free; response due
  // LATENCY-1 sample points later, unit free again LATENCY cycles after acceptance.
  always @(posedge clk) begin : model
    int pre, n, idx;
    bit e, known;
    logic [31:0] val;
    pre = cyc;
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        pend[i] = 1'b0;
        busy[i] = 0;
      end else if (v[i] && pre >= busy[i]) begin
        n = nb_of(sz[i]);
        e = is_err(sz[i], ad[i]);
        pend[i] = 1'b1;
        resp_at[i] = cyc + lat(i) - 1;
        busy[i] = cyc + lat(i);
        exp_e[i] = e;
        exp_d[i] = '0;
        exp_known[i] = 1'b1;
        if (!e && w[i]) begin
          for (int k = 0; k < n; k++) begin
            idx = int'(ad[i][9:0]) + k;
            mm[i][idx] = 8'(wd[i] >> (8 * (n - 1 - k)));
            mk[i][idx] = 1'b1;
          end
        end else if (!e) begin
          val = '0;
          known = 1'b1;
          for (int k = 0; k < n; k++) begin
            idx = int'(ad[i][9:0]) + k;
            val = (val << 8) | 32'(mm[i][idx]);
            known = known & mk[i][idx];
          end
          if (sg[i] && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
          exp_d[i] = val;
          exp_known[i] = known;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    bit er, ev;
    for (int i = 0; i < 2; i++) begin
      er = !reset && (cyc >= busy[i]);
      ev = !reset && pend[i] && (cyc == resp_at[i]);
      check($sformatf("req_ready[%0d]@%0d", i, cyc), {31'd0, rdy[i]}, {31'd0, er});
      check($sformatf("resp_valid[%0d]@%0d", i, cyc), {31'd0, rv[i]}, {31'd0, ev});
      check($sformatf("resp_err[%0d]@%0d", i, cyc), {31'd0, re[i]}, {31'd0, ev && exp_e[i]});
      if (!ev || exp_known[i])
        check($sformatf("resp_rdata[%0d]@%0d", i, cyc), rd[i], ev ? exp_d[i] : 32'd0);
    end
  end

  task automatic drive(input int i, input bit wr, input bit [1:0] s, input bit sgn,
                       input bit [31:0] a, input bit [31:0] data);
    v[i] = 1'b1; w[i] = wr; sz[i] = s; sg[i] = sgn; ad[i] = a; wd[i] = data;
  endtask

  task automatic wait_accept(input int i, input bit keep);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rdy[i]) begin got = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    if (!keep) v[i] = 1'b0;
    acc_cyc[i] = cyc;
    check($sformatf("accept_seen[%0d]", i), {31'd0, got}, 32'd1);
  endtask

  task automatic wait_resp(input int i, input logic [31:0] d, input bit e, input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rv[i]) begin got = 1'b1; break; end
    end
    resp_cyc[i] = cyc;
    check({name, "_seen"}, {31'd0, got}, 32'd1);
    if (got) begin
      check({name, "_rdata"}, rd[i], d);
      check({name, "_err"}, {31'd0, re[i]}, {31'd0, e});
    end
  endtask

  task automatic xact(input int i, input bit wr, input bit [1:0] s, input bit sgn,
                      input bit [31:0] a, input bit [31:0] data,
                      input logic [31:0] d, input bit e, input string name);
    drive(i, wr, s, sgn, a, data);
    wait_accept(i, 1'b0);
    wait_resp(i, d, e, name);
  endtask

  initial begin : stim
    int a1;
    bit saw;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; w[i] = 1'b0; sz[i] = 2'b00; sg[i] = 1'b0; ad[i] = '0; wd[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    xact(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, "st_w10");
    a1 = acc_cyc[0];
    xact(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, "ld_w10");
    check("l1_resp_delay", resp_cyc[0] - acc_cyc[0], 0);
    check("l1_period", acc_cyc[0] - a1, 2);
    xact(0, 0, 2'b00, 0, 32'h11, 32'h0, 32'h000000AD, 0, "ld_b11");
    xact(0, 0, 2'b00, 1, 32'h10, 32'h0, 32'hFFFFFFDE, 0, "ld_sb10");
    xact(0, 0, 2'b01, 0, 32'h12, 32'h0, 32'h0000BEEF, 0, "ld_h12");
    xact(0, 0, 2'b01, 1, 32'h12, 32'h0, 32'hFFFFBEEF, 0, "ld_sh12");
    xact(0, 0, 2'b01, 1, 32'h10, 32'h0, 32'hFFFFDEAD, 0, "ld_sh10");

    xact(0, 1, 2'b10, 0, 32'h00, 32'hA1B2C3D4, 32'h0, 0, "st_w00");
    xact(0, 0, 2'b10, 0, 32'h12, 32'h0, 32'h0, 1, "err_ld_w12");
    xact(0, 1, 2'b01, 0, 32'h03, 32'h0000FFFF, 32'h0, 1, "err_st_h03");
    xact(0, 0, 2'b11, 0, 32'h00, 32'h0, 32'h0, 1, "err_size11");
    xact(0, 1, 2'b11, 0, 32'h00, 32'hFFFFFFFF, 32'h0, 1, "err_st_size11");
    xact(0, 0, 2'b10, 0, D - 2, 32'h0, 32'h0, 1, "err_ld_w_end");
    xact(0, 1, 2'b00, 0, D, 32'h000000FF, 32'h0, 1, "err_st_b_oob");
    xact(0, 0, 2'b10, 0, 32'h00, 32'h0, 32'hA1B2C3D4, 0, "ld_w00_unchanged");
    xact(0, 1, 2'b10, 0, D - 4, 32'hCAFEF00D, 32'h0, 0, "st_w_last");
    xact(0, 0, 2'b10, 0, D - 4, 32'h0, 32'hCAFEF00D, 0, "ld_w_last");
    xact(0, 0, 2'b00, 1, D - 1, 32'h0, 32'h0000000D, 0, "ld_sb_last");

    xact(0, 1, 2'b00, 0, 32'h40, 32'h00000011, 32'h0, 0, "st_b40");
    xact(0, 1, 2'b00, 0, 32'h41, 32'h00000022, 32'h0, 0, "st_b41");
    xact(0, 1, 2'b00, 0, 32'h42, 32'h00000033, 32'h0, 0, "st_b42");
    xact(0, 1, 2'b00, 0, 32'h43, 32'h00000044, 32'h0, 0, "st_b43");
    xact(0, 0, 2'b10, 0, 32'h40, 32'h0, 32'h11223344, 0, "ld_w40");

    xact(1, 1, 2'b10, 0, 32'h30, 32'h0BADF00D, 32'h0, 0, "l4_st_w30");
    check("l4_resp_delay", resp_cyc[1] - acc_cyc[1], 3);
    drive(1, 0, 2'b10, 0, 32'h30, 32'h0);
    wait_accept(1, 1'b1);
    a1 = acc_cyc[1];
    wait_accept(1, 1'b0);
    check("l4_held_period", acc_cyc[1] - a1, 5);
    wait_resp(1, 32'h0BADF00D, 0, "l4_ld_w30");
    xact(1, 1, 2'b11, 0, 32'h24, 32'h1, 32'h0, 1, "l4_err_size11");
    check("l4_err_delay", resp_cyc[1] - acc_cyc[1], 3);

    drive(1, 1, 2'b10, 0, 32'h20, 32'h12345678);
    wait_accept(1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    saw = 1'b0;
    repeat (2) begin @(negedge clk); saw = saw | rv[1]; end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) begin @(negedge clk); saw = saw | rv[1]; end
    check("l4_reset_abort", {31'd0, saw}, 32'd0);
    xact(1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h12345678, 0, "l4_ld_w20_after_reset");
    xact(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, "l1_mem_kept");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
